countdown_display: RTL and testbench

- Consumer side of the countdown timer's minute/second outputs: drives a 4-digit multiplexed, common-anode 7-segment display as MM:SS.
- Registers a consistent snapshot of the time once per scan frame and converts it to decimal digits.
- Blinks the display while the timer is paused or has expired, and flags expiry to the top level.

---
 rtl/countdown_display.sv | 113 +++++++++++
 tb/tb_countdown_display.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/countdown_display.sv
// countdown_display: multiplexed 4-digit common-anode MM:SS display with per-frame snapshot, blink and expiry flag
module countdown_display #(
    parameter int SCAN_DIV  = 4000,
    parameter int BLINK_DIV = 2_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] minute,
    input  logic [5:0] second,
    input  logic       pause,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       expired
);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(BLINK_DIV);

    logic [SW-1:0] scan_cnt;
    logic [BW-1:0] blink_cnt;
    logic [1:0]    digit;
    logic [6:0]    snap_min;
    logic [5:0]    snap_sec;
    logic          blink_on;
    logic          tick;
    logic          active;
    logic          blank;
    logic [6:0]    min_sat;
    logic [3:0]    m_t;
    logic [3:0]    m_o;
    logic [3:0]    s_t;
    logic [3:0]    s_o;
    logic [3:0]    sel;

    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'd0:    enc = 7'h40;
            4'd1:    enc = 7'h79;
            4'd2:    enc = 7'h24;
            4'd3:    enc = 7'h30;
            4'd4:    enc = 7'h19;
            4'd5:    enc = 7'h12;
            4'd6:    enc = 7'h02;
            4'd7:    enc = 7'h78;
            4'd8:    enc = 7'h00;
            4'd9:    enc = 7'h10;
            default: enc = 7'h7F;
        endcase
    endfunction

    assign tick    = scan_cnt == SW'(SCAN_DIV - 1);
    assign active  = pause | expired;
    assign blank   = active & ~blink_on;
    assign min_sat = snap_min > 7'd99 ? 7'd99 : snap_min;
    assign m_t     = 4'(min_sat / 7'd10);
    assign m_o     = 4'(min_sat % 7'd10);
    assign s_t     = 4'(snap_sec / 6'd10);
    assign s_o     = 4'(snap_sec % 6'd10);
    assign sel     = digit == 2'd0 ? s_o : digit == 2'd1 ? s_t : digit == 2'd2 ? m_o : m_t;

    // Digit scan; the time is sampled only as the last digit slot ends so a frame never mixes old and new values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            digit    <= 2'd0;
            snap_min <= 7'd0;
            snap_sec <= 6'd0;
            expired  <= 1'b0;
        end else begin
            scan_cnt <= tick ? '0 : scan_cnt + SW'(1);
            if (tick)
                digit <= digit + 2'd1;
            if (tick && digit == 2'd3) begin
                snap_min <= minute;
                snap_sec <= second;
                expired  <= minute == 7'd0 && second == 6'd0;
            end
        end
    end

    // Blink phase runs only while paused or expired, otherwise parked visible so resume is immediate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (!active) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
        end else begin
            blink_cnt <= blink_cnt + BW'(1);
        end
    end

    // Registered drive of the current digit, with minute-tens zero blanking and the colon on digit 2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= 4'b1111;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else if (blank) begin
            an  <= 4'b1111;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an  <= ~(4'b0001 << digit);
            seg <= (digit == 2'd3 && m_t == 4'd0) ? 7'h7F : enc(sel);
            dp  <= digit != 2'd2;
        end
    end
endmodule

// File: tb/tb_countdown_display.sv
// tb_countdown_display: directed scoreboard bench for the multiplexed countdown display
module tb_countdown_display;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [6:0] minute;
    logic [5:0] second;
    logic       pause;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       expired;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       ex;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   slot_no = 0;
    int   nb;
    int   first;

    countdown_display #(.SCAN_DIV(4), .BLINK_DIV(8)) dut (
        .clk(clk), .rst_n(rst_n), .minute(minute), .second(second), .pause(pause),
        .an(an), .seg(seg), .dp(dp), .expired(expired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] want);
        n_checks++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s (slot %0d): observed %h expected %h", tag, slot_no, obs, want);
        end
    endtask

    task automatic push_slot(input int k, input logic [6:0] s, input logic ex, input bit bl);
        exp_t e;
        e.an  = bl ? 4'b1111 : ~(4'b0001 << k);
        e.seg = bl ? 7'h7F : s;
        e.dp  = bl ? 1'b1 : (k != 2);
        e.ex  = ex;
        q.push_back(e);
    endtask

    task automatic push_frame(input logic [6:0] s0, s1, s2, s3, input logic ex);
        push_slot(0, s0, ex, 0);
        push_slot(1, s1, ex, 0);
        push_slot(2, s2, ex, 0);
        push_slot(3, s3, ex, 0);
    endtask

    task automatic check_slot();
        exp_t e;
        chk("sb_nonempty", 8'(q.size() != 0), 8'd1);
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("an", 8'(an), 8'(e.an));
            chk("seg", 8'(seg), 8'(e.seg));
            chk("dp", 8'(dp), 8'(e.dp));
            chk("expired", 8'(expired), 8'(e.ex));
        end
        slot_no++;
    endtask

    task automatic run_slots(input int n);
        for (int i = 0; i < n; i++) begin
            check_slot();
            repeat (4) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        minute = 7'd25;
        second = 6'd7;
        pause  = 1'b0;
        #2 rst_n = 1'b0;
        #20;
        chk("rst_an", 8'(an), 8'h0F);
        chk("rst_seg", 8'(seg), 8'h7F);
        chk("rst_dp", 8'(dp), 8'd1);
        chk("rst_expired", 8'(expired), 8'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        push_frame(7'h40, 7'h40, 7'h40, 7'h7F, 0);
        run_slots(4);
        push_frame(7'h78, 7'h40, 7'h12, 7'h24, 0);
        run_slots(1);
        minute = 7'd12;
        second = 6'd34;
        run_slots(3);
        push_frame(7'h19, 7'h30, 7'h24, 7'h79, 0);
        run_slots(2);
        minute = 7'd13;
        run_slots(2);
        push_frame(7'h19, 7'h30, 7'h30, 7'h79, 0);
        run_slots(1);
        minute = 7'd120;
        second = 6'd61;
        run_slots(3);
        push_frame(7'h79, 7'h02, 7'h10, 7'h10, 0);
        run_slots(4);
        pause = 1'b1;
        nb = 0;
        first = 0;
        for (int i = 1; i <= 28; i++) begin
            @(posedge clk);
            #1;
            if (an == 4'b1111) begin
                nb++;
                if (first == 0) first = i;
            end
        end
        chk("pause_blank_cycles", 8'(nb), 8'd12);
        chk("pause_first_blank", 8'(first), 8'd9);
        chk("pause_expired", 8'(expired), 8'd0);
        pause = 1'b0;
        @(posedge clk);
        #1;
        chk("unpause_an", 8'(an), 8'h07);
        chk("unpause_seg", 8'(seg), 8'h10);
        repeat (3) @(posedge clk);
        #1;
        minute = 7'd0;
        second = 6'd0;
        push_frame(7'h79, 7'h02, 7'h10, 7'h10, 0);
        run_slots(4);
        for (int f = 0; f < 2; f++) begin
            push_slot(0, 7'h40, 1, 0);
            push_slot(1, 7'h40, 1, 0);
            push_slot(2, 7'h40, 1, 1);
            push_slot(3, 7'h7F, 1, 1);
        end
        run_slots(5);
        minute = 7'd5;
        run_slots(3);
        push_frame(7'h40, 7'h40, 7'h12, 7'h7F, 0);
        run_slots(4);
        push_slot(0, 7'h40, 0, 0);
        push_slot(1, 7'h40, 0, 0);
        push_slot(2, 7'h12, 0, 0);
        run_slots(2);
        check_slot();
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_an", 8'(an), 8'h0F);
        chk("async_rst_seg", 8'(seg), 8'h7F);
        chk("async_rst_dp", 8'(dp), 8'd1);
        chk("async_rst_expired", 8'(expired), 8'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        push_frame(7'h40, 7'h40, 7'h40, 7'h7F, 0);
        run_slots(4);
        chk("sb_drained", 8'(q.size()), 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
